// File: rtl/uart_tx_wrapped.sv
// uart_tx_wrapped
//   Bus-attached UART transmitter: a byte FIFO fed by register writes,
//   drained by an 8N1 serializer.
//
//   Register map (addr[1:0] ignored):
//     0x0 DATA   W: push wdata[7:0] (dropped and ovf set when full)
//                R: reads 0
//     0x4 STATUS R: {16'b0, level[7:0], 4'b0, ovf, empty, full, busy}
//                W: wdata[3]=1 clears ovf
//     0x8/0xC    reads 0, writes ignored
//
//   Ports:
//     i_clk    clock, rising edge
//     i_rst    synchronous active-high reset
//     i_req    bus request, held until o_ack
//     i_we     1 = write, 0 = read
//     i_addr   byte offset
//     i_wdata  write data
//     o_rdata  read data, non-zero only in the ack cycle
//     o_ack    one-cycle completion pulse
//     o_tx     serial output, idle high, driven from a flop
module uart_tx_wrapped #(
  parameter int CLKS_PER_BIT = 234,
  parameter int DEPTH        = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [3:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ack,
  output logic        o_tx
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    r_mem [DEPTH];
  logic [AW:0]   r_wptr, r_rptr;
  logic          r_ovf;
  logic          r_ack;
  logic [31:0]   r_rdata;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;

  logic [AW:0]   w_level;
  logic          w_empty, w_full, w_busy;
  logic          w_txn, w_sel_data, w_sel_stat;
  logic          w_wr_data, w_push, w_pop;
  logic          w_ovf_clr;
  logic [31:0]   w_status;
  logic          w_tx_nxt;
  logic          w_unused;

  // Pointers carry one extra wrap bit so full and empty are distinct.
  assign w_level = r_wptr - r_rptr;
  assign w_empty = (w_level == '0);
  assign w_full  = (w_level == (AW+1)'(DEPTH));
  assign w_busy  = (r_state != S_IDLE);

  // A request seen during the ack cycle is the tail of the previous
  // transaction, not a new one; a request during reset is ignored.
  assign w_txn      = i_req & ~r_ack & ~i_rst;
  assign w_sel_data = (i_addr[3:2] == 2'b00);
  assign w_sel_stat = (i_addr[3:2] == 2'b01);
  assign w_wr_data  = w_txn & i_we & w_sel_data;
  // Full is judged on occupancy before the edge, so a pop in the same
  // cycle never frees a slot for this push.
  assign w_push     = w_wr_data & ~w_full;
  assign w_pop      = (r_state == S_IDLE) & ~w_empty;
  assign w_ovf_clr  = w_txn & i_we & w_sel_stat & i_wdata[3];

  assign w_status = {16'b0, {(7-AW){1'b0}}, w_level, 4'b0,
                     r_ovf, w_empty, w_full, w_busy};

  always_comb begin
    w_tx_nxt = 1'b1;
    case (r_state)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = r_shift[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata[7:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_ovf   <= 1'b0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_ack   <= w_txn;
      r_rdata <= (w_txn & ~i_we & w_sel_stat) ? w_status : 32'd0;
      r_tx    <= w_tx_nxt;

      if (w_push) r_wptr <= r_wptr + 1'b1;

      if (w_wr_data & w_full) r_ovf <= 1'b1;
      else if (w_ovf_clr)     r_ovf <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift <= r_mem[r_rptr[AW-1:0]];
            r_rptr  <= r_rptr + 1'b1;
            r_cnt   <= CNT_LOAD;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_cnt == '0) begin
            r_cnt   <= CNT_LOAD;
            r_bit   <= '0;
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == '0) begin
            r_cnt   <= CNT_LOAD;
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit == 3'd7) r_state <= S_STOP;
            else               r_bit   <= r_bit + 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == '0) r_state <= S_IDLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Byte-offset low bits and upper write-data bits carry no meaning.
  assign w_unused = ^{i_addr[1:0], i_wdata[31:8]};

  assign o_ack   = r_ack;
  assign o_rdata = r_rdata;
  assign o_tx    = r_tx;

endmodule

// File: tb/tb_uart_tx_wrapped.sv
// Directed bench for uart_tx_wrapped with CLKS_PER_BIT=4, DEPTH=8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_uart_tx_wrapped;

  logic        clk, rst, req, we;
  logic [3:0]  addr;
  logic [31:0] wdata, rdata;
  logic        ack, tx;

  int checks = 0;
  int fails  = 0;

  uart_tx_wrapped #(.CLKS_PER_BIT(4), .DEPTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .o_rdata(rdata), .o_ack(ack), .o_tx(tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One bus transaction: ack must follow the sampling edge directly, then
  // drop with rdata back to zero the cycle after.
  task automatic bus(input logic w, input logic [3:0] a, input logic [31:0] d,
                     input logic [31:0] exp, input string nm);
    req = 1'b1; we = w; addr = a; wdata = d;
    step();
    chk({nm, " ack"}, {31'b0, ack}, 32'd1);
    chk({nm, " rdata"}, rdata, exp);
    req = 1'b0;
    step();
    chk({nm, " ack_drop"}, {31'b0, ack}, 32'd0);
    chk({nm, " rdata_drop"}, rdata, 32'd0);
  endtask

  // Called at the first sample where tx should be low; checks 40 samples
  // (start, 8 data LSB first, stop) and the idle-high sample after.
  task automatic check_frame(input logic [7:0] b, input string nm);
    logic e;
    for (int k = 0; k < 40; k++) begin
      if (k < 4)       e = 1'b0;
      else if (k < 36) e = b[(k-4)/4];
      else             e = 1'b1;
      chk($sformatf("%s tx[%0d]", nm, k), {31'b0, tx}, {31'b0, e});
      step();
    end
    chk({nm, " tx_after"}, {31'b0, tx}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;

    tbl[0] = '{1'b0, 4'h4, 32'h0,         32'h0000_0004};
    tbl[1] = '{1'b0, 4'h0, 32'h0,         32'h0};
    tbl[2] = '{1'b0, 4'h8, 32'h0,         32'h0};
    tbl[3] = '{1'b1, 4'h8, 32'hDEAD_BEEF, 32'h0};
    tbl[4] = '{1'b0, 4'hC, 32'h0,         32'h0};
    tbl[5] = '{1'b1, 4'hC, 32'h0000_00AA, 32'h0};
    tbl[6] = '{1'b1, 4'h4, 32'hFFFF_FFFF, 32'h0};
    tbl[7] = '{1'b0, 4'h4, 32'h0,         32'h0000_0004};
    tbl[8] = '{1'b0, 4'h5, 32'h0,         32'h0000_0004};
    tbl[9] = '{1'b0, 4'h6, 32'h0,         32'h0000_0004};

    step(); step(); step();
    rst = 1'b0;
    chk("reset tx", {31'b0, tx}, 32'd1);
    chk("reset ack", {31'b0, ack}, 32'd0);
    chk("reset rdata", rdata, 32'd0);

    // Register map vectors: no bytes may be queued by any of these.
    for (int i = 0; i < 10; i++)
      bus(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp, $sformatf("vec%0d", i));
    chk("no_frame tx", {31'b0, tx}, 32'd1);

    // Single byte 0x55: pushed at E0, popped at E1, tx falls at E2.
    bus(1'b1, 4'h0, 32'h55, 32'h0, "wr55");
    chk("wr55 tx_before_fall", {31'b0, tx}, 32'd1);
    step();
    check_frame(8'h55, "f55");
    bus(1'b0, 4'h4, 32'h0, 32'h0000_0004, "post55 status");

    // Back-to-back frames with exactly one idle cycle between them.
    bus(1'b1, 4'h0, 32'hA5, 32'h0, "wrA5");
    fork
      bus(1'b1, 4'h0, 32'h3C, 32'h0, "wr3C");
      begin
        step();
        check_frame(8'hA5, "fA5");
        step();
        check_frame(8'h3C, "f3C");
      end
    join
    bus(1'b0, 4'h4, 32'h0, 32'h0000_0004, "post3C status");

    // Reset during bit 3 of 0xFF with three bytes queued behind it.
    bus(1'b1, 4'h0, 32'hFF, 32'h0, "wrFF");
    bus(1'b1, 4'h0, 32'h11, 32'h0, "wr11");
    bus(1'b1, 4'h0, 32'h22, 32'h0, "wr22");
    bus(1'b1, 4'h0, 32'h33, 32'h0, "wr33");
    for (int i = 0; i < 12; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort tx", {31'b0, tx}, 32'd1);
    bus(1'b0, 4'h4, 32'h0, 32'h0000_0004, "abort status");
    begin
      int lows = 0;
      for (int i = 0; i < 60; i++) begin
        if (tx !== 1'b1) lows++;
        step();
      end
      chk("abort no_frames", lows, 32'd0);
    end

    // Overflow: 10 writes at one per two cycles, only one pop possible.
    for (int i = 0; i < 10; i++)
      bus(1'b1, 4'h0, 32'(i + 1), 32'h0, $sformatf("fill%0d", i));
    bus(1'b0, 4'h4, 32'h0, 32'h0000_080B, "full status");
    bus(1'b1, 4'h4, 32'h8, 32'h0, "ovf clear");
    bus(1'b0, 4'h4, 32'h0, 32'h0000_0803, "cleared status");
    do_reset();
    bus(1'b0, 4'h4, 32'h0, 32'h0000_0004, "post_reset status");

    // A request held for three cycles gives two transactions, never two
    // consecutive acks.
    req = 1'b1; we = 1'b0; addr = 4'h4;
    step();
    chk("hold ack0", {31'b0, ack}, 32'd1);
    chk("hold rdata0", rdata, 32'h0000_0004);
    step();
    chk("hold ack1", {31'b0, ack}, 32'd0);
    step();
    chk("hold ack2", {31'b0, ack}, 32'd1);
    req = 1'b0;
    step();
    chk("hold ack3", {31'b0, ack}, 32'd0);

    // A request coinciding with reset is not acked.
    rst = 1'b1; req = 1'b1; we = 1'b0; addr = 4'h4;
    step();
    chk("rst_req ack", {31'b0, ack}, 32'd0);
    rst = 1'b0; req = 1'b0;
    step();
    chk("rst_req ack_after", {31'b0, ack}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
